// File: rtl/blink_rate_decoder_if.sv
// blink_rate_decoder_if
// Groups the blink decoder's data signals into one bundle.
//   blink_in    : raw blinking square wave, asynchronous to the system clock
//   rate_code   : decoded switch code, 2'b11 means the wave has stopped
//   locked      : rate_code is confirmed and current
//   meas_valid  : one-cycle pulse per completed edge-to-edge measurement
//   half_period : last measured edge-to-edge interval in clocks
//   level_out   : synchronized copy of blink_in
// The master modport drives blink_in and observes the results.
// The slave modport is the decoder itself.
interface blink_rate_decoder_if #(
  parameter int CNT_W = 28
);
  logic             blink_in;
  logic [1:0]       rate_code;
  logic             locked;
  logic             meas_valid;
  logic [CNT_W-1:0] half_period;
  logic             level_out;

  modport master (
    output blink_in,
    input  rate_code, locked, meas_valid, half_period, level_out
  );

  modport slave (
    input  blink_in,
    output rate_code, locked, meas_valid, half_period, level_out
  );
endinterface

// File: rtl/blink_rate_decoder.sv
// blink_rate_decoder
// Measures the interval between transitions of a blinking input.
// Decodes which of three blink rates is present, or that the wave has stopped.
// Recovers the 2-bit switch code used at the transmitting blinker.
// Ports:
//   CLOCK_50 : system clock, all logic on the rising edge
//   KEY0     : asynchronous active-low reset
//   bus      : slave side of blink_rate_decoder_if
//              (blink_in in; rate_code, locked, meas_valid, half_period, level_out out)
module blink_rate_decoder #(
  parameter int HALF_FAST = 25_000_000,
  parameter int HALF_MED  = 50_000_000,
  parameter int HALF_SLOW = 90_000_000,
  parameter int TOL       = 1_000_000,
  parameter int CNT_W     = 28
) (
  input logic                  CLOCK_50,
  input logic                  KEY0,
  blink_rate_decoder_if.slave  bus
);

  typedef enum logic {S_WAIT, S_RUN} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(HALF_SLOW + TOL + 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] FAST_LO = CNT_W'(HALF_FAST - TOL);
  localparam logic [CNT_W-1:0] FAST_HI = CNT_W'(HALF_FAST + TOL);
  localparam logic [CNT_W-1:0] MED_LO  = CNT_W'(HALF_MED - TOL);
  localparam logic [CNT_W-1:0] MED_HI  = CNT_W'(HALF_MED + TOL);
  localparam logic [CNT_W-1:0] SLOW_LO = CNT_W'(HALF_SLOW - TOL);
  localparam logic [CNT_W-1:0] SLOW_HI = CNT_W'(HALF_SLOW + TOL);

  localparam logic [1:0] CODE_FAST = 2'b01;
  localparam logic [1:0] CODE_MED  = 2'b00;
  localparam logic [1:0] CODE_SLOW = 2'b10;
  localparam logic [1:0] CODE_STOP = 2'b11;

  logic sync1, sync2, dly, edge_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rate_q, rate_d;
  logic             locked_q, locked_d;
  logic             mv_q, mv_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [1:0]       cand_q, cand_d;
  logic             cand_valid_q, cand_valid_d;

  logic [1:0] cls;
  logic       cls_ok;

  // Synchronizer, delay flop and registered edge flag.
  // The extra edge register gives a fixed three-cycle input-to-output latency.
  // Because every edge sees the same delay, measured intervals stay exact.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      dly    <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync1  <= bus.blink_in;
      sync2  <= sync1;
      dly    <= sync2;
      edge_q <= sync2 ^ dly;
    end
  end

  // Window classification of the interval that ends at the current edge.
  // The running count equals the interval whenever an edge is being processed.
  always_comb begin
    cls    = CODE_MED;
    cls_ok = 1'b1;
    if (cnt_q >= FAST_LO && cnt_q <= FAST_HI) begin
      cls = CODE_FAST;
    end else if (cnt_q >= MED_LO && cnt_q <= MED_HI) begin
      cls = CODE_MED;
    end else if (cnt_q >= SLOW_LO && cnt_q <= SLOW_HI) begin
      cls = CODE_SLOW;
    end else begin
      cls_ok = 1'b0;
    end
  end

  // Next-state logic for the measurement FSM and its datapath.
  // The counter restarts at 1 on each edge, so at the next edge it holds the interval.
  // The counter saturates at TIMEOUT rather than wrapping.
  // An edge takes priority over a timeout in the same cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + ONE;
    rate_d       = rate_q;
    locked_d     = locked_q;
    mv_d         = 1'b0;
    hp_d         = hp_q;
    cand_d       = cand_q;
    cand_valid_d = cand_valid_q;

    case (state_q)
      S_WAIT: begin
        if (edge_q) begin
          state_d  = S_RUN;
          cnt_d    = ONE;
          locked_d = 1'b0;
        end
      end
      S_RUN: begin
        if (edge_q) begin
          mv_d  = 1'b1;
          hp_d  = cnt_q;
          cnt_d = ONE;
          if (!cls_ok) begin
            locked_d     = 1'b0;
            cand_valid_d = 1'b0;
          end else if (cand_valid_q && cand_q == cls) begin
            rate_d   = cls;
            locked_d = 1'b1;
          end else begin
            cand_d       = cls;
            cand_valid_d = 1'b1;
            locked_d     = 1'b0;
          end
        end else if (cnt_q == TIMEOUT) begin
          rate_d       = CODE_STOP;
          locked_d     = 1'b1;
          cand_valid_d = 1'b0;
          state_d      = S_WAIT;
        end
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  // State and output registers.
  // Reset discards any partial measurement, so the next edge is only a reference.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q      <= S_WAIT;
      cnt_q        <= '0;
      rate_q       <= CODE_MED;
      locked_q     <= 1'b0;
      mv_q         <= 1'b0;
      hp_q         <= '0;
      cand_q       <= 2'b00;
      cand_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rate_q       <= rate_d;
      locked_q     <= locked_d;
      mv_q         <= mv_d;
      hp_q         <= hp_d;
      cand_q       <= cand_d;
      cand_valid_q <= cand_valid_d;
    end
  end

  assign bus.rate_code   = rate_q;
  assign bus.locked      = locked_q;
  assign bus.meas_valid  = mv_q;
  assign bus.half_period = hp_q;
  assign bus.level_out   = sync2;

endmodule

// File: tb/tb_blink_rate_decoder.sv
// tb_blink_rate_decoder
// Self-checking bench for blink_rate_decoder with small timing parameters.
// A timestamp-based reference model predicts every output on every cycle.
// Directed scenarios add literal expectations at key points.
// A randomized phase mixes rates, off-window intervals, stops and resets.
module tb_blink_rate_decoder;

  localparam int HF  = 25;
  localparam int HM  = 50;
  localparam int HS  = 90;
  localparam int TL  = 2;
  localparam int CW  = 8;
  localparam int TMO = HS + TL + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  blink_rate_decoder_if #(.CNT_W(CW)) bus ();

  blink_rate_decoder #(
    .HALF_FAST (HF),
    .HALF_MED  (HM),
    .HALF_SLOW (HS),
    .TOL       (TL),
    .CNT_W     (CW)
  ) dut (
    .CLOCK_50 (clk),
    .KEY0     (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: absolute cycle numbers rather than counters.
  int m_cyc    = 0;
  int m_last_t = 0;
  int m_cand   = -1;
  bit m_wait   = 1'b1;
  int m_rate   = 0;
  int m_locked = 0;
  int m_mv     = 0;
  int m_hp     = 0;
  int m_lvl    = 0;
  int m_sample = 0;
  int pending[$];

  // Map an interval to its switch code, or -1 when it fits no window.
  function automatic int classify(input int m);
    if (m >= HF - TL && m <= HF + TL) return 1;
    if (m >= HM - TL && m <= HM + TL) return 0;
    if (m >= HS - TL && m <= HS + TL) return 2;
    return -1;
  endfunction

  task automatic modelReset();
    m_wait   = 1'b1;
    m_cand   = -1;
    m_rate   = 0;
    m_locked = 0;
    m_mv     = 0;
    m_hp     = 0;
    m_lvl    = 0;
    m_sample = 0;
    pending.delete();
  endtask

  // An edge seen at the input shows up in the outputs three edges later.
  task automatic modelEdge();
    int m;
    int c;
    if (m_wait) begin
      m_wait   = 1'b0;
      m_locked = 0;
    end else begin
      m    = m_cyc - m_last_t;
      m_mv = 1;
      m_hp = m;
      c    = classify(m);
      if (c < 0) begin
        m_locked = 0;
        m_cand   = -1;
      end else if (c == m_cand) begin
        m_rate   = c;
        m_locked = 1;
      end else begin
        m_cand   = c;
        m_locked = 0;
      end
    end
    m_last_t = m_cyc;
  endtask

  task automatic modelStep();
    int captured;
    m_cyc++;
    m_mv     = 0;
    captured = int'(bus.blink_in);
    if (captured != m_sample) pending.push_back(m_cyc + 3);
    m_lvl    = m_sample;
    m_sample = captured;
    if (pending.size() > 0 && pending[0] == m_cyc) begin
      void'(pending.pop_front());
      modelEdge();
    end else if (!m_wait && (m_cyc - m_last_t) == TMO) begin
      m_rate   = 3;
      m_locked = 1;
      m_cand   = -1;
      m_wait   = 1'b1;
    end
  endtask

  // Model advances on the same events as the DUT, including async reset.
  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else        modelStep();
    end
  end

  task automatic checkValue(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0d want %0d", name, m_cyc, got, want);
    end
  endtask

  // Literal expectations from hand calculation; hp < 0 skips half_period.
  task automatic checkOutput(input string tag, input int rate, input int locked,
                             input int mv, input int hp);
    checkValue({tag, ".rate_code"}, int'(bus.rate_code), rate);
    checkValue({tag, ".locked"}, int'(bus.locked), locked);
    checkValue({tag, ".meas_valid"}, int'(bus.meas_valid), mv);
    if (hp >= 0) checkValue({tag, ".half_period"}, int'(bus.half_period), hp);
  endtask

  // Every falling edge, compare all outputs with the model.
  initial begin
    forever begin
      @(negedge clk);
      checkValue("model.rate_code", int'(bus.rate_code), m_rate);
      checkValue("model.locked", int'(bus.locked), m_locked);
      checkValue("model.meas_valid", int'(bus.meas_valid), m_mv);
      checkValue("model.half_period", int'(bus.half_period), m_hp);
      checkValue("model.level_out", int'(bus.level_out), m_lvl);
    end
  end

  // Toggle blink_in gap cycles after the previous toggle.
  // Then wait until that edge's results are visible on the outputs.
  task automatic applyStimulus(input int gap);
    repeat (gap - 4) @(negedge clk);
    bus.blink_in = ~bus.blink_in;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulseReset(input logic level_during);
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.blink_in = level_during;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int kind;
    int center;
    int n;
    bus.blink_in = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset", 0, 0, 0, 0);
    checkValue("reset.level_out", int'(bus.level_out), 0);
    #2 rst_n = 1'b1;

    repeat (TMO + 5) @(negedge clk);
    checkOutput("idle_no_timeout", 0, 0, 0, 0);

    applyStimulus(10); checkOutput("ref_edge", 0, 0, 0, 0);
    applyStimulus(HM); checkOutput("med_first", 0, 0, 1, 50);
    applyStimulus(HM); checkOutput("med_lock", 0, 1, 1, 50);
    applyStimulus(HM); checkOutput("med_hold", 0, 1, 1, 50);
    applyStimulus(HF); checkOutput("fast_first", 0, 0, 1, 25);
    applyStimulus(HF); checkOutput("fast_lock", 1, 1, 1, 25);
    applyStimulus(88); checkOutput("slow_lo", 1, 0, 1, 88);
    applyStimulus(92); checkOutput("slow_hi", 2, 1, 1, 92);
    applyStimulus(93); checkOutput("edge_at_timeout", 2, 0, 1, 93);
    applyStimulus(90); checkOutput("after_invalid", 2, 0, 1, 90);
    applyStimulus(HF); checkOutput("fast_again", 2, 0, 1, 25);
    applyStimulus(HF); checkOutput("fast_relock", 1, 1, 1, 25);

    repeat (TMO - 1) @(negedge clk);
    checkOutput("pre_timeout", 1, 1, 0, 25);
    @(negedge clk);
    checkOutput("timeout", 3, 1, 0, 25);

    applyStimulus(10); checkOutput("restart_ref", 3, 0, 0, 25);
    applyStimulus(HS); checkOutput("slow_first", 3, 0, 1, 90);
    applyStimulus(HS); checkOutput("slow_lock", 2, 1, 1, 90);

    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    bus.blink_in = 1'b0;
    #1 checkOutput("async_reset", 0, 0, 0, 0);
    checkValue("async_reset.level_out", int'(bus.level_out), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    applyStimulus(20); checkOutput("post_reset_ref", 0, 0, 0, 0);
    applyStimulus(HS); checkOutput("post_reset_first", 0, 0, 1, 90);
    applyStimulus(HS); checkOutput("post_reset_lock", 2, 1, 1, 90);

    for (int i = 0; i < 30; i++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0, 1, 2: begin
          center = (kind == 0) ? HF : (kind == 1) ? HM : HS;
          n = int'($urandom_range(2, 4));
          for (int j = 0; j < n; j++) begin
            applyStimulus(center + int'($urandom_range(0, 8)) - 4);
          end
        end
        3: applyStimulus(int'($urandom_range(95, 130)));
        4: applyStimulus(int'($urandom_range(5, 20)));
        default: begin
          repeat (int'($urandom_range(1, 30))) @(negedge clk);
          pulseReset(logic'($urandom_range(0, 1)));
          repeat (5) @(negedge clk);
        end
      endcase
    end

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blink_rate_decoder.md
# blink_rate_decoder

Receive-side counterpart of the switch-controlled LED blinker. The block samples a blinking square wave on one input pin, which can come from another board running the blinker. It measures the time between transitions and decodes which of the three blink rates is present, or whether the wave has stopped. It recovers the same 2-bit switch code that selected the rate at the transmitter, for display on LEDR/LEDG.

## Interface
- HALF_FAST, 25_000_000, half-period in clocks for code 2'b01 (SW[0]=1, SW[1]=0)
- HALF_MED, 50_000_000, half-period in clocks for code 2'b00
- HALF_SLOW, 90_000_000, half-period in clocks for code 2'b10 (SW[0]=0, SW[1]=1)
- TOL, 1_000_000, accepted deviation in clocks, inclusive, each side
- CNT_W, 28, counter and half_period width; must hold HALF_SLOW+TOL+1
- CLOCK_50  in  1  system clock, 50 MHz, all logic on rising edge
- KEY0  in  1  reset, asynchronous, active-low (pushbutton)
- blink_in  in  1  blinking input, asynchronous to CLOCK_50
- rate_code  out  2  decoded switch code; 2'b11 = stopped
- locked  out  1  rate_code is confirmed and current
- meas_valid  out  1  one-cycle pulse per completed measurement
- half_period  out  CNT_W  last measured edge-to-edge interval in clocks
- level_out  out  1  synchronized copy of blink_in, for mirroring on LEDG[0]

## Operation
- blink_in passes through a 2-flop synchronizer, then a delay flop. The edge pulse is asserted when the synchronized value differs from the delayed value. Both rising and falling edges count.
- Measurement M is the number of clocks between consecutive edge pulses.
- Classification of M (inclusive windows):
  - [HALF_FAST±TOL] -> 01
  - [HALF_MED±TOL] -> 00
  - [HALF_SLOW±TOL] -> 10
  - any other value -> INVALID
- The FSM has two states:
  - S_WAIT: no reference edge yet. The first edge pulse only starts timing: go to S_RUN. No meas_valid is produced. locked is cleared to 0.
  - S_RUN: each edge pulse completes a measurement. It drives meas_valid=1 and half_period=M, then classifies M, then restarts timing from that edge.
- Confirmation (in S_RUN):
  - A valid class equal to the previous measurement's class -> rate_code takes that class, locked=1.
  - A valid class differing from the previous one -> it becomes the new candidate, locked=0, rate_code holds.
  - INVALID -> locked=0, rate_code holds, candidate cleared.
- Timeout:
  - In S_RUN, if the elapsed count reaches TIMEOUT = HALF_SLOW+TOL+1 without an edge: rate_code=11, locked=1, candidate cleared, go to S_WAIT.
  - The counter saturates; no wrap-around is allowed.
- Simultaneous edge and timeout in the same cycle: the edge wins. It is processed as a measurement with M=TIMEOUT, which classifies INVALID. No timeout is declared.

## Timing
- Reset (KEY0=0, asynchronous, effective immediately):
  - rate_code=2'b00, locked=0, meas_valid=0, half_period=0, level_out=0
  - synchronizer and delay flops cleared, counter=0, candidate cleared, state S_WAIT
- Reset deassertion is used as-is. The source is a debounced board key; no reset synchronizer is required.
- Latency: a blink_in transition captured at rising edge k produces level_out at edge k+1. meas_valid, half_period, rate_code and locked update on edge k+3. This latency is fixed, so M is exact.
- All outputs are registered.
- meas_valid is high for exactly one cycle per measurement.
- A blink_in pulse shorter than 2 clocks may be missed. This is acceptable.
- Reset mid-measurement discards the partial count. The next edge after release is treated as a reference only.

## Test plan
All scenarios use HALF_FAST=25, HALF_MED=50, HALF_SLOW=90, TOL=2, CNT_W=8 (TIMEOUT=93).
- Reset, no input activity -> rate_code=00, locked=0, meas_valid=0, half_period=0. After 93 cycles with no edge: still locked=0 (S_WAIT does not time out).
- Toggle every 50 clocks for 4 edges:
  - 1st edge -> no pulse.
  - 2nd edge -> meas_valid, half_period=50, locked=0.
  - 3rd edge -> rate_code=00, locked=1.
- Locked at 00, then switch to 25-clock toggles:
  - 1st 25 measurement -> locked=0, rate_code=00.
  - 2nd -> rate_code=01, locked=1.
- Boundaries at the slow rate:
  - Intervals 88 then 92 -> rate_code=10, locked=1.
  - Next interval 93 -> meas_valid with half_period=93, locked=0, rate_code stays 10.
  - Edge arriving exactly at count 93 -> INVALID, not stopped.
- Locked at 01, then hold blink_in -> 93 clocks after the last edge: rate_code=11, locked=1. Next edge -> locked=0, no meas_valid.
- Locked at 10, KEY0 pulsed low midway between edges -> all outputs reset in the same cycle. The following edge gives no meas_valid. The next two 90-clock intervals -> rate_code=10, locked=1.
